bin16_bcd_display: RTL and testbench

Sequential binary-to-BCD converter and seven-segment driver that sits directly downstream of the 8x8 multiplier. It takes the 16-bit product, converts it to five BCD digits with a shift-and-add-3 (double-dabble) engine over 16 clock cycles, and drives HEX0–HEX4 with active-low segment codes. This replaces the per-digit divide/modulo decode of the product with one small, timing-friendly iterative datapath.

---
 rtl/bin16_bcd_display.sv | 137 +++++++++++++
 tb/tb_bin16_bcd_display.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bin16_bcd_display.sv
// Iterative 16-bit binary to five-digit BCD converter (double-dabble) driving
// five active-low seven-segment displays with optional leading-zero blanking.
module bin16_bcd_display #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_ZERO   = 7'b1000000;
  localparam logic [6:0] HEX_HI_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    add3 = (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  logic [0:0]  r_state;
  logic [15:0] r_bin;
  logic [19:0] r_scr;
  logic [4:0]  r_cnt;

  logic [19:0] w_adj;
  logic [19:0] w_scr_nxt;
  logic [15:0] w_bin_nxt;
  logic [4:0]  w_blank;
  logic [6:0]  w_hex [5];

  // Add-3 correction on every scratch digit ahead of the shift
  always_comb begin
    w_adj = 20'd0;
    for (int k = 0; k < 5; k++) begin
      w_adj[4*k +: 4] = add3(r_scr[4*k +: 4]);
    end
  end

  assign {w_scr_nxt, w_bin_nxt} = {w_adj, r_bin} << 6'd1;

  // Segment codes for the final scratch value, blanking zeros from the top down
  always_comb begin
    w_blank    = 5'd0;
    w_blank[4] = BLANK_LZ && (w_scr_nxt[19:16] == 4'd0);
    for (int k = 3; k >= 1; k--) begin
      w_blank[k] = w_blank[k+1] && (w_scr_nxt[4*k +: 4] == 4'd0);
    end
    for (int k = 0; k < 5; k++) begin
      if (w_blank[k]) begin
        w_hex[k] = SEG_BLANK;
      end else begin
        w_hex[k] = seg7(w_scr_nxt[4*k +: 4]);
      end
    end
  end

  // Control FSM, shift datapath and registered display outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= 16'd0;
      r_scr   <= 20'd0;
      r_cnt   <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= 20'd0;
      HEX0    <= SEG_ZERO;
      HEX1    <= HEX_HI_RST;
      HEX2    <= HEX_HI_RST;
      HEX3    <= HEX_HI_RST;
      HEX4    <= HEX_HI_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_bin   <= bin;
            r_scr   <= 20'd0;
            r_cnt   <= 5'd0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bin <= w_bin_nxt;
          r_scr <= w_scr_nxt;
          r_cnt <= r_cnt + 5'd1;
          // Last iteration publishes the shifted result directly
          if (r_cnt == 5'd15) begin
            bcd     <= w_scr_nxt;
            HEX0    <= w_hex[0];
            HEX1    <= w_hex[1];
            HEX2    <= w_hex[2];
            HEX3    <= w_hex[3];
            HEX4    <= w_hex[4];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin16_bcd_display.sv
// Directed and random checks of bin16_bcd_display, with a second instance
// built without leading-zero blanking.
module tb_bin16_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin = 16'd0;
  logic        busy, done, nb_busy, nb_done;
  logic [19:0] bcd, nb_bcd;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;
  logic [6:0]  nb_hex0, nb_hex1, nb_hex2, nb_hex3, nb_hex4;

  int n_chk = 0;
  int n_fail = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  bin16_bcd_display dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4)
  );

  bin16_bcd_display #(.BLANK_LZ(1'b0)) dut_nb (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .bin(bin),
    .busy(nb_busy), .done(nb_done), .bcd(nb_bcd),
    .HEX0(nb_hex0), .HEX1(nb_hex1), .HEX2(nb_hex2), .HEX3(nb_hex3), .HEX4(nb_hex4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mdl(input int v);
    mdl = {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
           4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One conversion: start pulse, bounded wait for done, timing checks
  task automatic conv(input logic [15:0] v, input string tag);
    int n;
    int bc;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    bc = (busy === 1'b1) ? 1 : 0;
    n  = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (busy === 1'b1 && done !== 1'b1) bc++;
    end
    chk({tag, " latency"}, 32'(n), 32'd16);
    chk({tag, " busy_cycles"}, 32'(bc), 32'd16);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    int last;
    int v;

    // Reset values
    reset = 1'b1;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bcd", 32'(bcd), 32'd0);
    chk("rst HEX0", 32'(HEX0), 32'(S0));
    chk("rst HEX4", 32'(HEX4), 32'(SB));
    chk("rst nb HEX1", 32'(nb_hex1), 32'(S0));
    reset = 1'b0;
    tick();

    conv(16'd65025, "c65025");
    chk("c65025 bcd", 32'(bcd), 32'h65025);
    chk("c65025 HEX", {HEX4, HEX3, HEX2, HEX1}, {S6, 7'b0010010, S0, S2});
    chk("c65025 HEX0", 32'(HEX0), 32'(S5));
    tick();
    chk("done one cycle", 32'(done), 32'd0);
    chk("hold bcd", 32'(bcd), 32'h65025);

    conv(16'd0, "c0");
    chk("c0 bcd", 32'(bcd), 32'h00000);
    chk("c0 HEX", {HEX4, HEX3, HEX2, HEX1}, {SB, SB, SB, SB});
    chk("c0 HEX0", 32'(HEX0), 32'(S0));
    chk("c0 nb HEX", {nb_hex4, nb_hex3, nb_hex2, nb_hex1}, {S0, S0, S0, S0});
    chk("c0 nb HEX0", 32'(nb_hex0), 32'(S0));

    // Back-to-back: start raised in the done cycle
    conv(16'd65535, "c65535");
    chk("c65535 bcd", 32'(bcd), 32'h65535);
    conv(16'd9, "c9");
    chk("c9 bcd", 32'(bcd), 32'h00009);
    chk("c9 HEX", {HEX4, HEX3, HEX2, HEX1}, {SB, SB, SB, SB});
    chk("c9 HEX0", 32'(HEX0), 32'(S9));
    conv(16'd1000, "c1000");
    chk("c1000 bcd", 32'(bcd), 32'h01000);
    chk("c1000 HEX", {HEX4, HEX3, HEX2, HEX1}, {SB, S1, S0, S0});
    chk("c1000 HEX0", 32'(HEX0), 32'(S0));
    chk("c1000 nb HEX4", 32'(nb_hex4), 32'(S0));
    tick();

    // Start during SHIFT is ignored
    start = 1'b1;
    bin   = 16'd1234;
    tick();
    start = 1'b0;
    n   = 0;
    cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 4) begin
        start = 1'b1;
        bin   = 16'd4321;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk("ign latency", 32'(n), 32'd16);
    chk("ign bcd", 32'(bcd), 32'h01234);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
    chk("ign extra done", 32'(cnt), 32'd0);

    // Reset aborts a running conversion
    start = 1'b1;
    bin   = 16'd40000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort bcd", 32'(bcd), 32'd0);
    chk("abort HEX", {HEX4, HEX3, HEX2, HEX1, HEX0}, {SB, SB, SB, SB, S0});
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
    chk("abort no done", 32'(cnt), 32'd0);
    conv(16'd77, "c77");
    chk("c77 bcd", 32'(bcd), 32'h00077);
    tick();

    // Reset beats start
    reset = 1'b1;
    start = 1'b1;
    bin   = 16'd5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_vs_start busy", 32'(busy), 32'd0);
    tick();
    chk("rst_vs_start idle", 32'(busy), 32'd0);

    // Start held high: restart every 17 cycles
    start = 1'b1;
    bin   = 16'd255;
    cnt   = 0;
    last  = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done === 1'b1) begin
        chk("held bcd", 32'(bcd), 32'h00255);
        if (last >= 0) chk("held period", 32'(c - last), 32'd17);
        last = c;
        cnt++;
      end
    end
    chk("held done count", 32'(cnt), 32'd3);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("held drain", 32'(done), 32'd1);
    tick();

    for (int i = 0; i < 256; i++) begin
      v = int'($urandom_range(0, 65535));
      conv(16'(v), "rnd");
      chk("rnd bcd", 32'(bcd), 32'(mdl(v)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
